// File: rtl/chain_codec_pkg.sv
// rtl/chain_codec_pkg.sv - shared types and constants for the chained-shift codec
package chain_codec_pkg;

  // Session state: waiting, collecting serial symbols, or running the shift chain.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PROC = 2'd2
  } state_t;

  localparam logic DIR_DEC  = 1'b0;
  localparam logic DIR_ENC  = 1'b1;
  localparam logic LOAD_PAR = 1'b0;
  localparam logic LOAD_SER = 1'b1;

endpackage

// File: rtl/chain_shift_step.sv
// rtl/chain_shift_step.sv - one symbol of the chained-shift cipher
module chain_shift_step
  import chain_codec_pkg::*;
#(
  parameter int SYM_W = 3
) (
  input  logic [SYM_W-1:0] in,
  input  logic [SYM_W-1:0] s,
  input  logic             dir,
  output logic [SYM_W-1:0] out,
  output logic [SYM_W-1:0] s_next
);

  // The carried shift is always the ciphertext symbol, so encode and decode invert each other.
  always_comb begin
    out    = in - s;
    s_next = in;
    if (dir == DIR_ENC) begin
      out    = in + s;
      s_next = in + s;
    end
  end

endmodule

// File: rtl/chain_shift_codec.sv
// rtl/chain_shift_codec.sv - session FSM, symbol counter, work register and output register
module chain_shift_codec
  import chain_codec_pkg::*;
#(
  parameter int SYM_W = 3,
  parameter int SYM_N = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   dir,
  input  logic                   load_mode,
  input  logic [SYM_W-1:0]       key,
  input  logic                   in_valid,
  input  logic                   abort,
  input  logic [SYM_N*SYM_W-1:0] data_in,
  output logic [SYM_N*SYM_W-1:0] data_out,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = (SYM_N > 1) ? $clog2(SYM_N) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SYM_N - 1);

  state_t                        state, state_next;
  logic [CNT_W-1:0]              cnt;
  logic [SYM_N-1:0][SYM_W-1:0]   work;
  logic [SYM_N-1:0][SYM_W-1:0]   work_final;
  logic [SYM_W-1:0]              s;
  logic [SYM_W-1:0]              sym_out;
  logic [SYM_W-1:0]              s_next;
  logic                          dir_q;
  logic                          accept;

  // A start is refused during the done cycle and whenever abort is also high.
  assign accept = start && !abort && !done;
  assign busy   = (state != IDLE);

  chain_shift_step #(.SYM_W(SYM_W)) u_step (
    .in     (work[cnt]),
    .s      (s),
    .dir    (dir_q),
    .out    (sym_out),
    .s_next (s_next)
  );

  // Work register with the current symbol already replaced, used for the final output load.
  always_comb begin
    work_final      = work;
    work_final[cnt] = sym_out;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; abort wins in LOAD/PROC, and the last PROC symbol returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (load_mode == LOAD_SER) ? LOAD : PROC;
      LOAD: begin
        if (abort)                        state_next = IDLE;
        else if (in_valid && cnt == '0)   state_next = PROC;
      end
      PROC: begin
        if (abort || cnt == '0)           state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture session parameters, fill the work register, run the chain, publish result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      work     <= '0;
      s        <= '0;
      dir_q    <= DIR_DEC;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dir_q <= dir;
            s     <= key;
            cnt   <= CNT_TOP;
            if (load_mode == LOAD_PAR) work <= data_in;
          end
        end
        LOAD: begin
          if (!abort && in_valid) begin
            work[cnt] <= data_in[SYM_W-1:0];
            cnt       <= (cnt == '0) ? CNT_TOP : cnt - 1'b1;
          end
        end
        PROC: begin
          if (!abort) begin
            work[cnt] <= sym_out;
            s         <= s_next;
            if (cnt == '0) begin
              done     <= 1'b1;
              data_out <= work_final;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chain_shift_codec.sv
// tb/tb_chain_shift_codec.sv - scoreboard bench for chain_shift_codec (SYM_W=3, SYM_N=4)
module tb_chain_shift_codec;

  localparam int W  = 3;
  localparam int N  = 4;
  localparam int WW = W * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          dir;
  logic          load_mode;
  logic [W-1:0]  key;
  logic          in_valid;
  logic          abort;
  logic [WW-1:0] data_in;
  logic [WW-1:0] data_out;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] last_out;

  chain_shift_codec #(.SYM_W(W), .SYM_N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .load_mode (load_mode),
    .key       (key),
    .in_valid  (in_valid),
    .abort     (abort),
    .data_in   (data_in),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [WW-1:0] model(input logic d, input logic [W-1:0] k, input logic [WW-1:0] x);
    logic [W-1:0]  sh;
    logic [W-1:0]  a;
    logic [W-1:0]  r;
    logic [WW-1:0] y;
    sh = k;
    y  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      a = x[i*W +: W];
      if (d) begin r = a + sh; sh = r; end
      else   begin r = a - sh; sh = a; end
      y[i*W +: W] = r;
    end
    return y;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after the session entered PROC.
  task automatic wait_done(input string tag);
    int lat;
    logic [WW-1:0] exp;
    lat = 1;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    if (!done) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_lat"}, 32'(lat), 32'(N + 1));
      check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check_eq({tag, "_data"}, 32'(data_out), 32'(exp));
      last_out  = exp;
      start     = 1'b1;
      load_mode = 1'b0;
      data_in   = ~data_in;
      step();
      start = 1'b0;
      check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
      check_eq({tag, "_start_in_done"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic run_par(input string tag, input logic d, input logic [W-1:0] k,
                         input logic [WW-1:0] x, input logic [WW-1:0] exp, input bit poke);
    exp_q.push_back(exp);
    dir = d; key = k; load_mode = 1'b0; data_in = x; start = 1'b1;
    step();
    start = poke;
    dir = ~d; key = W'($urandom); data_in = WW'($urandom);
    wait_done(tag);
    start = 1'b0;
  endtask

  task automatic run_ser(input string tag, input logic d, input logic [W-1:0] k,
                         input logic [N-1:0][W-1:0] word, input int gap_idx, input int gap_len,
                         input logic [WW-1:0] exp);
    exp_q.push_back(exp);
    dir = d; key = k; load_mode = 1'b1; start = 1'b1;
    in_valid = 1'b1; data_in = WW'($urandom);
    step();
    start = 1'b0; dir = ~d; key = W'($urandom);
    for (int j = N - 1; j >= 0; j--) begin
      in_valid = 1'b1;
      data_in  = WW'($urandom);
      data_in[W-1:0] = word[j];
      step();
      in_valid = 1'b0;
      data_in  = WW'($urandom);
      if (j == gap_idx) repeat (gap_len) step();
    end
    wait_done(tag);
  endtask

  initial begin
    logic [WW-1:0] x;
    logic [W-1:0]  k;
    bit saw_done;
    rst = 1'b1; start = 1'b0; dir = 1'b0; load_mode = 1'b0; key = '0;
    in_valid = 1'b0; abort = 1'b0; data_in = '0; last_out = '0;
    step(); step();
    rst = 1'b0;
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);

    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_eq("abort_beats_start", 32'(busy), 32'd0);

    run_par("dec_par", 1'b0, 3'd1, 12'h747, 12'h49F, 1'b0);
    run_par("enc_par", 1'b1, 3'd1, 12'h49F, 12'h747, 1'b1);
    run_ser("dec_ser", 1'b0, 3'd1, 12'h747, 2, 2, 12'h49F);
    run_par("dec_wrap", 1'b0, 3'd0, 12'hFFF, 12'hE00, 1'b0);
    run_par("enc_wrap", 1'b1, 3'd0, 12'hE00, 12'hFFF, 1'b0);

    // Abort in the second PROC cycle.
    dir = 1'b0; key = 3'd2; load_mode = 1'b0; data_in = 12'h123; start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_data", 32'(data_out), 32'(last_out));
    saw_done = 1'b0;
    repeat (6) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check_eq("abort_no_done", 32'(saw_done), 32'd0);
    run_par("after_abort", 1'b0, 3'd1, 12'h747, 12'h49F, 1'b0);

    for (int i = 0; i < 4; i++) begin
      x = WW'($urandom);
      k = W'($urandom);
      run_par("rnd_enc", 1'b1, k, x, model(1'b1, k, x), 1'b0);
      run_par("rnd_roundtrip", 1'b0, k, last_out, x, 1'b0);
    end

    // Reset in the middle of a serial load, with start held while busy.
    dir = 1'b0; key = 3'd1; load_mode = 1'b1; start = 1'b1; in_valid = 1'b0;
    step();
    start = 1'b1;
    in_valid = 1'b1; data_in = 12'h003;
    step();
    data_in = 12'h005;
    step();
    check_eq("load_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    check_eq("midrst_data", 32'(data_out), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    saw_done = 1'b0;
    repeat (6) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    check_eq("midrst_quiet", 32'(saw_done), 32'd0);
    run_ser("ser_after_rst", 1'b1, 3'd5, 12'h1A3, 0, 0, model(1'b1, 3'd5, 12'h1A3));

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
